// File: rtl/sm_cmp_stream.sv
// Two-stage streaming signed-magnitude comparator with valid/ready flow control and a peak tracker.
// Optional SM_CMP_STATS_EN adds saturating ge_cnt/tot_cnt statistics counters and ports.
module sm_cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ageb,
  output logic             aeqb,
  output logic             agtb,
  output logic [WIDTH-1:0] max_out,
  input  logic             clr,
  output logic [WIDTH-1:0] peak_out,
  output logic             peak_valid
`ifdef SM_CMP_STATS_EN
  ,
  output logic [CNT_W-1:0] ge_cnt,
  output logic [CNT_W-1:0] tot_cnt
`endif
);

  if (WIDTH < 2 || WIDTH > 32 || CNT_W < 2) begin : gBadParam
    $error("sm_cmp_stream: WIDTH must be 2..32 and CNT_W at least 2");
  end

  // Signed-magnitude to two's complement; -0 collapses to 0.
  function automatic logic signed [WIDTH-1:0] smToTc(input logic [WIDTH-1:0] sm);
    logic signed [WIDTH-1:0] mag;
    mag = {1'b0, sm[WIDTH-2:0]};
    if (sm[WIDTH-1]) begin
      return -mag;
    end else begin
      return mag;
    end
  endfunction

  // Two's complement back to canonical signed-magnitude (zero is always +0).
  function automatic logic [WIDTH-1:0] tcToSm(input logic signed [WIDTH-1:0] tc);
    logic [WIDTH-1:0] neg;
    neg = -tc;
    if (tc[WIDTH-1]) begin
      return {1'b1, neg[WIDTH-2:0]};
    end else begin
      return {1'b0, tc[WIDTH-2:0]};
    end
  endfunction

  logic                    s1Valid_r;
  logic signed [WIDTH-1:0] s1A_r;
  logic signed [WIDTH-1:0] s1B_r;
  logic                    s2Adv_s;
  logic                    inReady_s;
  logic                    accept_s;
  logic                    deliver_s;
  logic                    geS_s;
  logic                    eqS_s;
  logic                    gtS_s;
  logic [WIDTH-1:0]        maxSm_s;
  logic                    baseValid_s;
  logic [WIDTH-1:0]        basePeak_s;
  logic                    peakValidNext_s;
  logic [WIDTH-1:0]        peakNext_s;

  // Handshake decode; in_ready deliberately follows out_ready within the cycle.
  always_comb begin
    s2Adv_s   = s1Valid_r && (!out_valid || out_ready);
    inReady_s = !rst && (!s1Valid_r || s2Adv_s);
    accept_s  = in_valid && inReady_s;
    deliver_s = out_valid && out_ready;
  end

  assign in_ready = inReady_s;

  // Signed compare of the stage-1 values and selection of the larger operand.
  always_comb begin
    geS_s = (s1A_r >= s1B_r);
    eqS_s = (s1A_r == s1B_r);
    gtS_s = (s1A_r > s1B_r);
    if (geS_s) begin
      maxSm_s = tcToSm(s1A_r);
    end else begin
      maxSm_s = tcToSm(s1B_r);
    end
  end

  // Stage 1: capture operands already converted to two's complement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_r <= 1'b0;
      s1A_r     <= {WIDTH{1'b0}};
      s1B_r     <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      s1Valid_r <= 1'b1;
      s1A_r     <= smToTc(a_in);
      s1B_r     <= smToTc(b_in);
    end else if (s2Adv_s) begin
      s1Valid_r <= 1'b0;
    end
  end

  // Stage 2: result registers, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ageb      <= 1'b0;
      aeqb      <= 1'b0;
      agtb      <= 1'b0;
      max_out   <= {WIDTH{1'b0}};
    end else if (s2Adv_s) begin
      out_valid <= 1'b1;
      ageb      <= geS_s;
      aeqb      <= eqS_s;
      agtb      <= gtS_s;
      max_out   <= maxSm_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Peak next-state: clr clears first, then a coincident delivery may load.
  always_comb begin
    baseValid_s     = peak_valid;
    basePeak_s      = peak_out;
    peakValidNext_s = peak_valid;
    peakNext_s      = peak_out;
    if (clr) begin
      baseValid_s = 1'b0;
      basePeak_s  = {WIDTH{1'b0}};
    end else begin
      baseValid_s = peak_valid;
      basePeak_s  = peak_out;
    end
    if (deliver_s && (!baseValid_s || (smToTc(max_out) > smToTc(basePeak_s)))) begin
      peakValidNext_s = 1'b1;
      peakNext_s      = max_out;
    end else begin
      peakValidNext_s = baseValid_s;
      peakNext_s      = basePeak_s;
    end
  end

  // Peak tracker state.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_out   <= {WIDTH{1'b0}};
    end else begin
      peak_valid <= peakValidNext_s;
      peak_out   <= peakNext_s;
    end
  end

`ifdef SM_CMP_STATS_EN
  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [CNT_W-1:0] geBase_s;
  logic [CNT_W-1:0] totBase_s;
  logic [CNT_W-1:0] geNext_s;
  logic [CNT_W-1:0] totNext_s;

  // Counter next-state, with the same clear-then-count ordering as the peak.
  always_comb begin
    geBase_s  = ge_cnt;
    totBase_s = tot_cnt;
    geNext_s  = ge_cnt;
    totNext_s = tot_cnt;
    if (clr) begin
      geBase_s  = {CNT_W{1'b0}};
      totBase_s = {CNT_W{1'b0}};
    end else begin
      geBase_s  = ge_cnt;
      totBase_s = tot_cnt;
    end
    if (deliver_s) begin
      totNext_s = satInc(totBase_s);
    end else begin
      totNext_s = totBase_s;
    end
    if (deliver_s && ageb) begin
      geNext_s = satInc(geBase_s);
    end else begin
      geNext_s = geBase_s;
    end
  end

  // Statistics counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ge_cnt  <= {CNT_W{1'b0}};
      tot_cnt <= {CNT_W{1'b0}};
    end else begin
      ge_cnt  <= geNext_s;
      tot_cnt <= totNext_s;
    end
  end
`endif

endmodule

// File: tb/tb_sm_cmp_stream.sv
// Self-checking bench for sm_cmp_stream: vector table through a scoreboard plus directed corner sequences.
module tb_sm_cmp_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic             ageb;
  logic             aeqb;
  logic             agtb;
  logic [WIDTH-1:0] max_out;
  logic             clr;
  logic [WIDTH-1:0] peak_out;
  logic             peak_valid;
`ifdef SM_CMP_STATS_EN
  logic [CNT_W-1:0] ge_cnt;
  logic [CNT_W-1:0] tot_cnt;
`endif

  sm_cmp_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .ageb(ageb), .aeqb(aeqb), .agtb(agtb), .max_out(max_out), .clr(clr),
    .peak_out(peak_out), .peak_valid(peak_valid)
`ifdef SM_CMP_STATS_EN
    , .ge_cnt(ge_cnt), .tot_cnt(tot_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] exp;
  } vec_t;

  vec_t        vecs[13];
  logic [10:0] sbQ[$];
  logic [10:0] curExp;
  int          nVec = 0;
  int          nErr = 0;
  int          nDeliv = 0;

  function automatic logic [10:0] mk(input logic ge, input logic eq, input logic gt, input logic [7:0] mx);
    return {ge, eq, gt, mx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [10:0] e);
    a_in     = a;
    b_in     = b;
    curExp   = e;
    in_valid = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40 && sbQ.size() != 0; i++) tick();
    check(name, sbQ.size(), 0);
  endtask

  // Scoreboard: push on accept, pop and compare on delivery, flush on reset.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
    end else begin
      if (in_valid && in_ready) sbQ.push_back(curExp);
      if (out_valid && out_ready) begin
        nDeliv++;
        if (sbQ.size() == 0) begin
          nVec++;
          nErr++;
          $display("FAIL unexpected_result: got 0x%0h with nothing pending", {ageb, aeqb, agtb, max_out});
        end else begin
          check("result", {ageb, aeqb, agtb, max_out}, sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    int acc;
    int stale;
    int delivBefore;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    a_in = 8'h00; b_in = 8'h00; curExp = 11'h000;

    vecs[0]  = '{8'h85, 8'h03, mk(1'b0, 1'b0, 1'b0, 8'h03)};
    vecs[1]  = '{8'h80, 8'h00, mk(1'b1, 1'b1, 1'b0, 8'h00)};
    vecs[2]  = '{8'h7F, 8'hFF, mk(1'b1, 1'b0, 1'b1, 8'h7F)};
    vecs[3]  = '{8'h00, 8'h80, mk(1'b1, 1'b1, 1'b0, 8'h00)};
    vecs[4]  = '{8'h80, 8'h80, mk(1'b1, 1'b1, 1'b0, 8'h00)};
    vecs[5]  = '{8'h83, 8'h85, mk(1'b1, 1'b0, 1'b1, 8'h83)};
    vecs[6]  = '{8'h85, 8'h83, mk(1'b0, 1'b0, 1'b0, 8'h83)};
    vecs[7]  = '{8'h05, 8'h05, mk(1'b1, 1'b1, 1'b0, 8'h05)};
    vecs[8]  = '{8'hFF, 8'hFF, mk(1'b1, 1'b1, 1'b0, 8'hFF)};
    vecs[9]  = '{8'hFF, 8'h80, mk(1'b0, 1'b0, 1'b0, 8'h00)};
    vecs[10] = '{8'h01, 8'h81, mk(1'b1, 1'b0, 1'b1, 8'h01)};
    vecs[11] = '{8'h10, 8'h7F, mk(1'b0, 1'b0, 1'b0, 8'h7F)};
    vecs[12] = '{8'h81, 8'h00, mk(1'b0, 1'b0, 1'b0, 8'h00)};

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_flags", {ageb, aeqb, agtb}, 0);
    check("rst_max_out", max_out, 0);
    check("rst_peak", {peak_valid, peak_out}, 0);
`ifdef SM_CMP_STATS_EN
    check("rst_counters", {ge_cnt, tot_cnt}, 0);
`endif
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Latency: accept in cycle n, out_valid in cycle n+2
    @(posedge clk); #1;
    send(vecs[0].a, vecs[0].b, vecs[0].exp);
    @(negedge clk);
    check("lat_n_accept", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_n2_out_valid", out_valid, 1);
    waitDrain("lat_drain");

    // Full-rate stream of the table
    for (int i = 1; i < 13; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].exp);
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    waitDrain("stream_drain");

    // Backpressure: only two pairs fit, then in_ready follows out_ready
    out_ready = 1'b0;
    acc = 0;
    delivBefore = nDeliv;
    for (int k = 0; k < 4; k++) begin
      send(vecs[k + 5].a, vecs[k + 5].b, vecs[k + 5].exp);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 2);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid_held", {out_valid, max_out}, {1'b1, 8'h83});
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rise", in_ready, 1);
    waitDrain("bp_drain");
    check("bp_deliveries", nDeliv - delivBefore, 2);

    // Peak tracking
    clr = 1'b1; tick(); clr = 1'b0;
    @(negedge clk);
    check("clr_peak", {peak_valid, peak_out}, 0);
`ifdef SM_CMP_STATS_EN
    check("clr_counters", {ge_cnt, tot_cnt}, 0);
`endif
    @(posedge clk); #1;
    send(8'h81, 8'hFF, mk(1'b1, 1'b0, 1'b1, 8'h81)); tick();
    send(8'hFF, 8'hFF, mk(1'b1, 1'b1, 1'b0, 8'hFF)); tick();
    send(8'h7F, 8'h00, mk(1'b1, 1'b0, 1'b1, 8'h7F)); tick();
    send(8'h10, 8'h05, mk(1'b1, 1'b0, 1'b1, 8'h10)); tick();
    in_valid = 1'b0;
    waitDrain("peak_drain");
    @(negedge clk);
    check("peak_max", {peak_valid, peak_out}, {1'b1, 8'h7F});

    // clr coincident with a delivery of max 0x90
    @(posedge clk); #1; out_ready = 1'b0;
    send(8'h90, 8'h9F, mk(1'b1, 1'b0, 1'b1, 8'h90)); tick();
    in_valid = 1'b0; tick();
    @(negedge clk);
    check("clrdel_pending", out_valid, 1);
    @(posedge clk); #1; clr = 1'b1; out_ready = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    check("clrdel_peak", {peak_valid, peak_out}, {1'b1, 8'h90});
`ifdef SM_CMP_STATS_EN
    check("clrdel_counters", {ge_cnt, tot_cnt}, {4'd1, 4'd1});
`endif

    // Twenty ageb=1 deliveries saturate the counters
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 10), 8'h83, mk(1'b1, 1'b0, 1'b1, 8'(i + 10)));
      tick();
    end
    in_valid = 1'b0;
    waitDrain("sat_drain");
    @(negedge clk);
    check("sat_peak", peak_out, 8'h1D);
`ifdef SM_CMP_STATS_EN
    check("sat_ge_cnt", ge_cnt, 15);
    check("sat_tot_cnt", tot_cnt, 15);
`endif

    // Reset with two pairs in flight
    @(posedge clk); #1; out_ready = 1'b0;
    send(vecs[0].a, vecs[0].b, vecs[0].exp); tick();
    send(vecs[3].a, vecs[3].b, vecs[3].exp); tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_loaded", out_valid, 1);
    @(posedge clk); #1; rst = 1'b1;
    tick(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_peak", {peak_valid, peak_out}, 0);
    check("midrst_result_regs", {ageb, aeqb, agtb, max_out}, 0);
`ifdef SM_CMP_STATS_EN
    check("midrst_counters", {ge_cnt, tot_cnt}, 0);
`endif
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
